// File: rtl/alu_cmd_ctrl_if.sv
`default_nettype none
//==============================================================================
// alu_cmd_ctrl_if : command, response and ALU-side signals of alu_cmd_ctrl
// Revision        : 1.0
//==============================================================================
interface alu_cmd_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_func;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_func;
    logic [WIDTH-1:0] alu_out;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [2:0]       rsp_func;

    // Front-end/ALU side: issues commands, consumes responses, computes results
    modport master (
        output cmd_valid, cmd_func, cmd_a, cmd_b, cmd_use_acc,
        input  cmd_ready,
        input  alu_a, alu_b, alu_func,
        output alu_out,
        input  rsp_valid, rsp_data, rsp_func,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_func, cmd_a, cmd_b, cmd_use_acc,
        output cmd_ready,
        output alu_a, alu_b, alu_func,
        input  alu_out,
        output rsp_valid, rsp_data, rsp_func,
        input  rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
//==============================================================================
// alu_cmd_ctrl : queues ALU commands in a FIFO and sequences them one at a time
// Revision     : 1.0
//==============================================================================
module alu_cmd_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_cmd_ctrl_if.slave            bus,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     busy_o
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_full_count = c_cw'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       mem_func_q [DEPTH];
    logic [WIDTH-1:0] mem_a_q    [DEPTH];
    logic [WIDTH-1:0] mem_b_q    [DEPTH];
    logic             mem_acc_q  [DEPTH];

    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]  count_q, count_d;

    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_func_q, alu_func_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_func_q, rsp_func_d;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;

    // Ready depends on the occupancy register only, never on cmd_valid
    assign bus.cmd_ready = (count_q != c_full_count);
    assign w_empty       = (count_q == '0);
    assign w_push        = bus.cmd_valid && bus.cmd_ready;

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_func  = alu_func_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_func  = rsp_func_q;
    assign fifo_count_o  = count_q;
    assign busy_o        = (state_q != IDLE) || !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_func_q[wr_ptr_q] <= bus.cmd_func;
            mem_a_q[wr_ptr_q]    <= bus.cmd_a;
            mem_b_q[wr_ptr_q]    <= bus.cmd_b;
            mem_acc_q[wr_ptr_q]  <= bus.cmd_use_acc;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_pop       = 1'b0;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_func_d  = alu_func_q;
        acc_d       = acc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_func_d  = rsp_func_q;

        unique case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    alu_func_d = mem_func_q[rd_ptr_q];
                    alu_b_d    = mem_b_q[rd_ptr_q];
                    alu_a_d    = mem_acc_q[rd_ptr_q] ? acc_q : mem_a_q[rd_ptr_q];
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = bus.alu_out;
                acc_d       = bus.alu_out;
                rsp_func_d  = alu_func_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_func_q  <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_func_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_func_q  <= alu_func_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_func_q  <= rsp_func_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_ctrl.sv
`default_nettype none
//==============================================================================
// tb_alu_cmd_ctrl : directed bench for alu_cmd_ctrl with a behavioural ALU
// Revision        : 1.0
//==============================================================================
module tb_alu_cmd_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] fifo_count;
    logic       busy;
    int         n_checks = 0;
    int         n_errors = 0;

    alu_cmd_ctrl_if #(.WIDTH(16)) bus ();

    alu_cmd_ctrl #(.WIDTH(16), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .fifo_count_o (fifo_count),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            3'b000:  return 16'h0000;
            3'b001:  return ~b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ~(a ^ b);
            3'b110:  return ~(a | b);
            default: return ~(a & b);
        endcase
    endfunction

    always_comb bus.alu_out = alu_ref(bus.alu_func, bus.alu_a, bus.alu_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b, input logic u);
        int n = 0;
        bus.cmd_func    = f;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_use_acc = u;
        bus.cmd_valid   = 1'b1;
        while (!bus.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        chk("push_ready", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [15:0] exp_d, input logic [2:0] exp_f);
        int n = 0;
        bus.rsp_ready = 1'b1;
        while (!bus.rsp_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, "_data"}, {16'd0, bus.rsp_data}, {16'd0, exp_d});
        chk({tag, "_func"}, {29'd0, bus.rsp_func}, {29'd0, exp_f});
        tick();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_alu_a"},     {16'd0, bus.alu_a},     32'd0);
        chk({tag, "_alu_b"},     {16'd0, bus.alu_b},     32'd0);
        chk({tag, "_alu_func"},  {29'd0, bus.alu_func},  32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"},  {16'd0, bus.rsp_data},  32'd0);
        chk({tag, "_rsp_func"},  {29'd0, bus.rsp_func},  32'd0);
        chk({tag, "_count"},     {29'd0, fifo_count},    32'd0);
        chk({tag, "_busy"},      {31'd0, busy},          32'd0);
        chk({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    logic [2:0]  w_f [10];
    logic [15:0] w_a [10];
    logic [15:0] w_b [10];
    logic        w_u [10];
    logic [15:0] w_e [10];

    initial begin
        logic [15:0] prev;
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_func    = '0;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.cmd_use_acc = 1'b0;
        bus.rsp_ready   = 1'b1;
        tick();
        tick();
        chk_reset("rst0");
        rst = 1'b0;
        tick();

        // First operation: load one edge after push, response two edges after
        push(3'b010, 16'hF0F0, 16'h0FF0, 1'b0);
        chk("t1_count", {29'd0, fifo_count}, 32'd1);
        tick();
        chk("t1_alu_a",    {16'd0, bus.alu_a},    32'h0000F0F0);
        chk("t1_alu_b",    {16'd0, bus.alu_b},    32'h00000FF0);
        chk("t1_alu_func", {29'd0, bus.alu_func}, 32'd2);
        chk("t1_no_rsp",   {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        chk("t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        wait_rsp("t1", 16'h00F0, 3'b010);
        chk("t1_cleared", {31'd0, bus.rsp_valid}, 32'd0);

        push(3'b001, 16'h1234, 16'h00FF, 1'b0);
        wait_rsp("not_b", 16'hFF00, 3'b001);
        push(3'b000, 16'hFFFF, 16'hFFFF, 1'b0);
        wait_rsp("zero", 16'h0000, 3'b000);

        // Accumulator chain
        push(3'b011, 16'h1200, 16'h0034, 1'b0);
        wait_rsp("acc_or", 16'h1234, 3'b011);
        push(3'b100, 16'hFFFF, 16'h00FF, 1'b1);
        tick();
        chk("acc_alu_a", {16'd0, bus.alu_a}, 32'h00001234);
        chk("acc_alu_b", {16'd0, bus.alu_b}, 32'h000000FF);
        wait_rsp("acc_xor", 16'h12CB, 3'b100);

        // Backpressure: 6 commands with the consumer stalled
        bus.rsp_ready = 1'b0;
        push(3'b010, 16'hFF00, 16'h0F0F, 1'b0);
        push(3'b011, 16'hF000, 16'h000F, 1'b0);
        push(3'b100, 16'hAAAA, 16'hFFFF, 1'b0);
        push(3'b101, 16'h1234, 16'h1234, 1'b0);
        push(3'b110, 16'h0F0F, 16'h00FF, 1'b0);
        bus.cmd_func  = 3'b111;
        bus.cmd_a     = 16'hFFFF;
        bus.cmd_b     = 16'h00FF;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready",  {31'd0, bus.cmd_ready}, 32'd0);
            chk("bp_count",  {29'd0, fifo_count},    32'd4);
            chk("bp_valid",  {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_stable", {16'd0, bus.rsp_data},  32'h00000F00);
            tick();
        end
        fork
            push(3'b111, 16'hFFFF, 16'h00FF, 1'b0);
            begin
                wait_rsp("bp1", 16'h0F00, 3'b010);
                wait_rsp("bp2", 16'hF00F, 3'b011);
                wait_rsp("bp3", 16'h5555, 3'b100);
                wait_rsp("bp4", 16'hFFFF, 3'b101);
                wait_rsp("bp5", 16'hF000, 3'b110);
                wait_rsp("bp6", 16'hFF00, 3'b111);
            end
        join
        chk("bp_drained", {29'd0, fifo_count}, 32'd0);

        // Simultaneous push and pop at count 2
        bus.rsp_ready = 1'b0;
        push(3'b011, 16'h0001, 16'h0002, 1'b0);
        push(3'b100, 16'h00FF, 16'h0F0F, 1'b0);
        push(3'b010, 16'hABCD, 16'h00FF, 1'b0);
        wait_rsp("pp1", 16'h0003, 3'b011);
        chk("pp_count_before", {29'd0, fifo_count}, 32'd2);
        push(3'b001, 16'h0000, 16'h5A5A, 1'b0);
        chk("pp_count_after", {29'd0, fifo_count}, 32'd2);
        wait_rsp("pp2", 16'h0FF0, 3'b100);
        wait_rsp("pp3", 16'h00CD, 3'b010);
        wait_rsp("pp4", 16'hA5A5, 3'b001);

        // Pointer wrap: 10 streamed commands, some chained through acc
        prev = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            w_f[i] = 3'(i);
            w_a[i] = 16'((i + 1) * 16'h1111);
            w_b[i] = 16'h0F0F ^ 16'(i * 16'h0123);
            w_u[i] = (i == 4) || (i == 7);
            w_e[i] = alu_ref(w_f[i], w_u[i] ? prev : w_a[i], w_b[i]);
            prev   = w_e[i];
        end
        fork
            for (int i = 0; i < 10; i++) push(w_f[i], w_a[i], w_b[i], w_u[i]);
            for (int j = 0; j < 10; j++) wait_rsp("wrap", w_e[j], w_f[j]);
        join

        // Reset during EXEC with 3 entries still queued
        bus.rsp_ready = 1'b0;
        push(3'b010, 16'hFFFF, 16'h1234, 1'b0);
        push(3'b011, 16'h1111, 16'h2222, 1'b0);
        push(3'b100, 16'h3333, 16'h4444, 1'b0);
        push(3'b101, 16'h5555, 16'h6666, 1'b0);
        push(3'b110, 16'h7777, 16'h8888, 1'b0);
        wait_rsp("rs1", 16'h1234, 3'b010);
        chk("rs_count4", {29'd0, fifo_count}, 32'd4);
        tick();
        chk("rs_count3", {29'd0, fifo_count}, 32'd3);
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset("rst_exec");
        tick();
        tick();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("post_rst_busy",  {31'd0, busy},          32'd0);
        end

        // Accumulator must have been cleared by reset
        push(3'b100, 16'hFFFF, 16'h00FF, 1'b1);
        tick();
        chk("acc_rst_alu_a", {16'd0, bus.alu_a}, 32'd0);
        wait_rsp("acc_rst", 16'h00FF, 3'b100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-side controller that drives the team's 16-bit combinational ALU (`a`, `b`, `func` in; `out` back). It accepts operation requests over a valid/ready handshake, queues them in a small FIFO, and presents one operation at a time on registered ALU operand/function ports. It captures the ALU result into a response register and an accumulator, and returns it over a second valid/ready handshake. It sits between a bus/sequencer front-end and a single ALU instance.

## Interface
- `WIDTH`, 16, operand/result width; matches ALU.
- `DEPTH`, 4, command FIFO entries; power of two.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept; equals `!full`.
- `cmd_func` in 3: ALU function code.
- `cmd_a` in WIDTH: operand A.
- `cmd_b` in WIDTH: operand B.
- `cmd_use_acc` in 1: substitute accumulator for operand A.
- `alu_a` out WIDTH: registered, to ALU `a`.
- `alu_b` out WIDTH: registered, to ALU `b`.
- `alu_func` out 3: registered, to ALU `func`.
- `alu_out` in WIDTH: ALU result, combinational from `alu_*`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_data` out WIDTH: result.
- `rsp_func` out 3: function code that produced `rsp_data`.
- `fifo_count` out log2(DEPTH)+1: queued entries, 0..DEPTH.
- `busy` out 1: `state != IDLE || fifo_count != 0`.

## Operation
- Function codes: 000 → 0, 001 ~b, 010 a&b, 011 a|b, 100 a^b, 101 ~(a^b), 110 ~(a|b), 111 ~(a&b). The controller passes codes through unchanged and never decodes them.
- Push when `cmd_valid && cmd_ready`. Each entry stores {func, a, b, use_acc}.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO non-empty, pop the head. Load `alu_func` and `alu_b`. Load `alu_a` with `use_acc ? acc : a`. Go to EXEC.
  - EXEC: the ALU inputs are stable. Capture `alu_out` into `rsp_data` and `acc`, and `alu_func` into `rsp_func`. Set `rsp_valid`. Go to RESP.
  - RESP: hold all outputs. On `rsp_valid && rsp_ready`, clear `rsp_valid` and go to IDLE.
- `alu_*` hold their last values outside IDLE→EXEC loads.
- `acc` is internal and updated only in EXEC. Its reset value is 0.
- A simultaneous push and pop in the same cycle is legal. `fifo_count` is then unchanged.
- Push while full is impossible because `cmd_ready` is 0. `cmd_valid` held while full is stalled, not dropped.
- Pointers wrap modulo DEPTH. Full and empty are derived from `fifo_count`.
- The consumer must not see `rsp_data`/`rsp_func` change while `rsp_valid=1`.

## Timing
- Reset (async assert, synchronous-clean deassert by the system):
  - State IDLE, FIFO empty, acc 0.
  - `alu_a=0`, `alu_b=0`, `alu_func=000`.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_func=000`.
  - `fifo_count=0`, `busy=0`, `cmd_ready=1`.
- Reset mid-operation aborts everything. Queued commands and any pending response are discarded.
- Latency, empty idle unit: push at edge k → pop and ALU load at edge k+1 → `rsp_valid`=1 after edge k+2.
- Minimum occupancy is 3 cycles per operation (IDLE, EXEC, RESP with `rsp_ready`=1).
- Back-to-back: a command is popped in the IDLE cycle after the RESP handshake.
- `use_acc` always sees the result of the immediately preceding operation. The accumulator is written in EXEC before the next IDLE load.
- `cmd_ready` is combinational from `fifo_count` only, with no path from `cmd_valid`. `rsp_valid` is registered.

## Test plan
- Reset, then push func=010, a=F0F0, b=0FF0 with `rsp_ready`=1 → `alu_a`/`alu_b`/`alu_func` = F0F0/0FF0/010 one edge after the push; `rsp_valid`=1 with `rsp_data`=00F0 and `rsp_func`=010 two edges after the push.
- Push func=001, b=00FF → `rsp_data`=FF00. Push func=000 → `rsp_data`=0000.
- Accumulator chain:
  - Push func=011, a=1200, b=0034 → 1234.
  - Then push func=100, use_acc=1, a=FFFF (ignored), b=00FF → `alu_a`=1234, `rsp_data`=12CB.
- Backpressure:
  - Hold `rsp_ready`=0 and push 6 commands → first popped, 4 queued, `cmd_ready`=0 with `fifo_count`=4, 6th stalled.
  - `rsp_data` stays stable while `rsp_valid`=1.
  - Release `rsp_ready` → all 6 results arrive in order.
- Simultaneous push/pop at `fifo_count`=2 → count stays 2 and no entry is lost.
- Pointer wrap: stream 10 commands → results in order, matching the ALU model.
- Assert `rst` during EXEC with 3 queued → all outputs at reset values immediately. After release, no stale response appears and `busy`=0.
